// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared constants for the pipeline hazard controller: FSM encodings,
// register-index width, NOP encoding and the debug state bundle.
package pipeline_hazard_ctrl_pkg;

    localparam int REG_W  = 4;
    localparam int INSN_W = 16;

    // Instruction word loaded into a pipeline register to form a bubble.
    localparam logic [INSN_W-1:0] NOP_INSN = 16'h0000;

    // Memory-port arbiter states.
    localparam logic [1:0] ARB_IDLE = 2'd0;
    localparam logic [1:0] ARB_I    = 2'd1;
    localparam logic [1:0] ARB_D    = 2'd2;

    // Halt sequencing states.
    localparam logic [1:0] HALT_RUN    = 2'd0;
    localparam logic [1:0] HALT_DRAIN  = 2'd1;
    localparam logic [1:0] HALT_HALTED = 2'd2;

    // Both FSM states, brought out for observation.
    typedef struct packed {
        logic [1:0] arb;
        logic [1:0] halt;
    } dbg_state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_mem_port_arbiter.sv
// Non-preemptive owner of the single memory port. D-cache beats I-cache
// when both ask in the same idle cycle; a grant is held until mem_done and
// the port always spends at least one cycle idle between owners.
module mem_port_arbiter
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       icache_miss,
    input  logic       dcache_miss,
    input  logic       mem_done,
    input  logic       allow_i,
    output logic       icache_grant,
    output logic       dcache_grant,
    output logic [1:0] state
);

    logic [1:0] state_next;

    // Next owner: grant only from idle, release only on mem_done.
    always_comb begin
        state_next = state;
        case (state)
            ARB_IDLE: begin
                if (dcache_miss)
                    state_next = ARB_D;
                else if (icache_miss && allow_i)
                    state_next = ARB_I;
            end
            ARB_I, ARB_D: begin
                if (mem_done)
                    state_next = ARB_IDLE;
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    // Owner register; reset drops any grant at the next edge.
    always_ff @(posedge clk) begin
        if (rst)
            state <= ARB_IDLE;
        else
            state <= state_next;
    end

    assign icache_grant = (state == ARB_I);
    assign dcache_grant = (state == ARB_D);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline. Hazard equations
// are combinational; the halt-drain sequencer and stall counter are
// registered; memory-port ownership lives in mem_port_arbiter.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_is_bcond,
    input  logic             id_is_hlt,
    input  logic             id_branch_taken,
    input  logic             id_ex_memread,
    input  logic [REG_W-1:0] id_ex_rd,
    input  logic             id_ex_sets_flags,
    input  logic             icache_miss,
    input  logic             dcache_miss,
    input  logic             mem_done,
    output logic             icache_grant,
    output logic             dcache_grant,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             id_ex_stall,
    output logic             ex_mem_stall,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             mem_wb_bubble,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cycles,
    output dbg_state_t       dbg_state
);

    localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    logic [1:0]     halt_state;
    logic [1:0]     arb_state;
    logic [DCW-1:0] drain_cnt;
    logic           dstall;
    logic           luse;
    logic           fstall;
    logic           hstall;

    assign dstall = dcache_miss;
    assign luse   = id_ex_memread && (id_ex_rd != '0) &&
                    ((id_uses_rs && (id_rs == id_ex_rd)) ||
                     (id_uses_rt && (id_rt == id_ex_rd)));
    assign fstall = id_is_bcond && id_ex_sets_flags;
    assign hstall = ((halt_state == HALT_RUN) && id_is_hlt) ||
                    (halt_state != HALT_RUN);

    // Prioritised stall/flush decode; everything quiet while in reset.
    always_comb begin
        pc_stall      = 1'b0;
        if_id_stall   = 1'b0;
        id_ex_stall   = 1'b0;
        ex_mem_stall  = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_bubble  = 1'b0;
        mem_wb_bubble = 1'b0;
        if (!rst) begin
            if (dstall) begin
                // Whole pipe frozen; WB sees a NOP so nothing retires twice.
                pc_stall      = 1'b1;
                if_id_stall   = 1'b1;
                id_ex_stall   = 1'b1;
                ex_mem_stall  = 1'b1;
                mem_wb_bubble = 1'b1;
            end else if (luse || fstall || hstall) begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_bubble = 1'b1;
            end else if (id_branch_taken && icache_miss) begin
                // Keep the branch in ID until the target fetch can proceed.
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_bubble = 1'b1;
            end else if (id_branch_taken) begin
                if_id_flush = 1'b1;
            end else if (icache_miss) begin
                pc_stall    = 1'b1;
                if_id_flush = 1'b1;
            end
        end
    end

    // Halt drain: count DRAIN_CYCLES un-frozen cycles after HLT leaves RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            halt_state <= HALT_RUN;
            drain_cnt  <= '0;
        end else begin
            case (halt_state)
                HALT_RUN: begin
                    if (id_is_hlt && !dstall) begin
                        halt_state <= HALT_DRAIN;
                        drain_cnt  <= '0;
                    end
                end
                HALT_DRAIN: begin
                    if (!dstall) begin
                        if (drain_cnt == DCW'(DRAIN_CYCLES - 1))
                            halt_state <= HALT_HALTED;
                        else
                            drain_cnt <= drain_cnt + DCW'(1);
                    end
                end
                HALT_HALTED: halt_state <= HALT_HALTED;
                default:     halt_state <= HALT_RUN;
            endcase
        end
    end

    // Saturating count of stalled cycles, excluding the halted idle state.
    always_ff @(posedge clk) begin
        if (rst)
            stall_cycles <= '0;
        else if (pc_stall && (halt_state != HALT_HALTED) && (stall_cycles != '1))
            stall_cycles <= stall_cycles + CNT_W'(1);
    end

    mem_port_arbiter u_arb (
        .clk          (clk),
        .rst          (rst),
        .icache_miss  (icache_miss),
        .dcache_miss  (dcache_miss),
        .mem_done     (mem_done),
        .allow_i      (halt_state == HALT_RUN),
        .icache_grant (icache_grant),
        .dcache_grant (dcache_grant),
        .state        (arb_state)
    );

    assign halted         = (halt_state == HALT_HALTED);
    assign dbg_state.arb  = arb_state;
    assign dbg_state.halt = halt_state;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: a spec-level model checked every cycle,
// directed scenarios with literal expectations, then random stimulus.
module tb_pipeline_hazard_ctrl;
    import pipeline_hazard_ctrl_pkg::*;

    localparam int DRAIN_CYCLES = 3;
    localparam int CNT_W        = 4;
    localparam int CNT_MAX      = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       id_rs, id_rt, id_ex_rd;
    logic             id_uses_rs, id_uses_rt, id_is_bcond, id_is_hlt;
    logic             id_branch_taken, id_ex_memread, id_ex_sets_flags;
    logic             icache_miss, dcache_miss, mem_done;
    logic             icache_grant, dcache_grant;
    logic             pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
    logic             if_id_flush, id_ex_bubble, mem_wb_bubble, halted;
    logic [CNT_W-1:0] stall_cycles;
    dbg_state_t       dbg_state;

    int compared   = 0;
    int mismatched = 0;

    pipeline_hazard_ctrl #(.DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_is_bcond(id_is_bcond), .id_is_hlt(id_is_hlt),
        .id_branch_taken(id_branch_taken), .id_ex_memread(id_ex_memread),
        .id_ex_rd(id_ex_rd), .id_ex_sets_flags(id_ex_sets_flags),
        .icache_miss(icache_miss), .dcache_miss(dcache_miss), .mem_done(mem_done),
        .icache_grant(icache_grant), .dcache_grant(dcache_grant),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
        .ex_mem_stall(ex_mem_stall), .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble), .mem_wb_bubble(mem_wb_bubble),
        .halted(halted), .stall_cycles(stall_cycles), .dbg_state(dbg_state)
    );

    // Clock / reset
    always #5 clk = ~clk;

    // Behavioural model: who owns the port, whether a HLT was accepted,
    // how many un-frozen edges have passed since, and the stall tally.
    bit model_valid = 0;
    bit m_gi = 0, m_gd = 0, m_started = 0;
    int m_drain = 0, m_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected {pc, if_id, id_ex_stall, ex_mem, flush, bubble, mem_wb}.
    function automatic logic [6:0] exp_ctrl();
        bit l, f, h;
        l = id_ex_memread && id_ex_rd != 0 &&
            ((id_uses_rs && id_rs == id_ex_rd) || (id_uses_rt && id_rt == id_ex_rd));
        f = id_is_bcond && id_ex_sets_flags;
        h = m_started || id_is_hlt;
        if (rst)                             return 7'b0000000;
        if (dcache_miss)                     return 7'b1111001;
        if (l || f || h)                     return 7'b1100010;
        if (id_branch_taken && icache_miss)  return 7'b1100010;
        if (id_branch_taken)                 return 7'b0000100;
        if (icache_miss)                     return 7'b1000100;
        return 7'b0000000;
    endfunction

    function automatic bit m_halted();
        return m_drain >= DRAIN_CYCLES + 1;
    endfunction

    always @(posedge clk) begin
        logic [6:0] c;
        if (rst) begin
            model_valid = 1;
            m_gi = 0; m_gd = 0; m_started = 0; m_drain = 0; m_cnt = 0;
        end else begin
            c = exp_ctrl();
            if (c[6] && !m_halted() && m_cnt < CNT_MAX) m_cnt++;
            if (m_gi || m_gd) begin
                if (mem_done) begin m_gi = 0; m_gd = 0; end
            end else if (dcache_miss) m_gd = 1;
            else if (icache_miss && !m_started) m_gi = 1;
            if (!m_started) begin
                if (id_is_hlt && !dcache_miss) begin m_started = 1; m_drain = 1; end
            end else if (!m_halted() && !dcache_miss) m_drain++;
        end
    end

    // Compare process
    always @(negedge clk) begin
        if (model_valid) begin
            check("ctrl", 32'({pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
                               if_id_flush, id_ex_bubble, mem_wb_bubble}), 32'(exp_ctrl()));
            check("grants", 32'({icache_grant, dcache_grant}), 32'({m_gi, m_gd}));
            check("halted", 32'(halted), 32'(m_halted()));
            check("stall_cycles", 32'(stall_cycles), 32'(m_cnt));
        end
    end

    // Driver tasks
    task automatic clear_inputs();
        id_rs = 0; id_rt = 0; id_ex_rd = 0; id_uses_rs = 0; id_uses_rt = 0;
        id_is_bcond = 0; id_is_hlt = 0; id_branch_taken = 0; id_ex_memread = 0;
        id_ex_sets_flags = 0; icache_miss = 0; dcache_miss = 0; mem_done = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1;
        clear_inputs();
        next_cycle();
        next_cycle();
        rst = 0;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic set_load_use();
        id_ex_memread = 1; id_ex_rd = 3; id_rs = 3; id_uses_rs = 1;
    endtask

    int edges;

    initial begin
        rst = 1;
        clear_inputs();
        // Reset with hazards present: every output must stay low.
        set_load_use();
        dcache_miss = 1;
        next_cycle();
        sample();
        check("rst_ctrl", 32'({pc_stall, if_id_stall, ex_mem_stall, mem_wb_bubble, id_ex_bubble}), 0);
        check("rst_regs", 32'({icache_grant, dcache_grant, halted, stall_cycles}), 0);
        do_reset();

        // Load-use: one-cycle bubble, then clear.
        set_load_use();
        sample();
        check("luse", 32'({pc_stall, if_id_stall, id_ex_bubble, id_ex_stall}), 32'b1110);
        next_cycle();
        clear_inputs();
        sample();
        check("luse_clear", 32'(pc_stall), 0);

        // Load into r0 is never a hazard.
        next_cycle();
        set_load_use();
        id_ex_rd = 0; id_rs = 0;
        sample();
        check("luse_r0", 32'({pc_stall, id_ex_bubble}), 0);

        // Flag hazard.
        next_cycle();
        clear_inputs();
        id_is_bcond = 1; id_ex_sets_flags = 1;
        sample();
        check("fstall", 32'({pc_stall, if_id_stall, id_ex_bubble}), 32'b111);

        // Simultaneous misses: D first, one idle cycle, then I.
        do_reset();
        icache_miss = 1; dcache_miss = 1;
        sample();
        check("arb_wait", 32'({icache_grant, dcache_grant}), 0);
        next_cycle();
        sample();
        check("arb_d_first", 32'({icache_grant, dcache_grant}), 32'b01);
        next_cycle();
        dcache_miss = 0; mem_done = 1;
        next_cycle();
        mem_done = 0;
        sample();
        check("arb_idle_gap", 32'({icache_grant, dcache_grant}), 0);
        next_cycle();
        sample();
        check("arb_i_next", 32'({icache_grant, dcache_grant}), 32'b10);

        // D miss during ARB_I: I keeps the port, pipe fully frozen.
        next_cycle();
        dcache_miss = 1;
        sample();
        check("i_held", 32'({icache_grant, dcache_grant}), 32'b10);
        check("freeze", 32'({ex_mem_stall, mem_wb_bubble, id_ex_stall}), 32'b111);
        next_cycle();
        icache_miss = 0; mem_done = 1;
        next_cycle();
        mem_done = 0;
        next_cycle();
        sample();
        check("d_after_i", 32'({icache_grant, dcache_grant}), 32'b01);
        // Reset mid-transfer drops the grant at the next edge.
        rst = 1;
        next_cycle();
        sample();
        check("rst_drop", 32'({icache_grant, dcache_grant}), 0);
        rst = 0;

        // HLT with no misses: halted after DRAIN_CYCLES+1 edges.
        do_reset();
        id_is_hlt = 1;
        edges = 0;
        for (int k = 1; k <= 20; k++) begin
            next_cycle();
            if (halted && edges == 0) edges = k;
        end
        check("halt_edges", 32'(edges), 32'(DRAIN_CYCLES + 1));

        // HLT with two D-miss cycles mid-drain: two extra edges.
        do_reset();
        id_is_hlt = 1;
        edges = 0;
        for (int k = 1; k <= 20; k++) begin
            next_cycle();
            dcache_miss = (k == 1 || k == 2);
            if (halted && edges == 0) edges = k;
        end
        check("halt_edges_dstall", 32'(edges), 32'(DRAIN_CYCLES + 3));

        // Counter saturation and reset.
        do_reset();
        set_load_use();
        repeat ((1 << CNT_W) + 5) next_cycle();
        sample();
        check("sat", 32'(stall_cycles), 32'(CNT_MAX));
        rst = 1;
        next_cycle();
        sample();
        check("sat_rst", 32'({stall_cycles, halted, pc_stall}), 0);
        rst = 0;

        // Random phase.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            next_cycle();
            rst              = ($urandom_range(0, 199) == 0);
            id_rs            = 4'($urandom_range(0, 3));
            id_rt            = 4'($urandom_range(0, 3));
            id_ex_rd         = 4'($urandom_range(0, 3));
            id_uses_rs       = 1'($urandom_range(0, 1));
            id_uses_rt       = 1'($urandom_range(0, 1));
            id_ex_memread    = ($urandom_range(0, 3) == 0);
            id_is_bcond      = ($urandom_range(0, 3) == 0);
            id_ex_sets_flags = 1'($urandom_range(0, 1));
            id_is_hlt        = ($urandom_range(0, 79) == 0);
            id_branch_taken  = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 5) == 0) icache_miss = ~icache_miss;
            if ($urandom_range(0, 6) == 0) dcache_miss = ~dcache_miss;
            mem_done         = ($urandom_range(0, 3) == 0);
            if (halted && $urandom_range(0, 9) == 0) rst = 1;
        end

        next_cycle();
        sample();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
